// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// CPU-visible CTRL/PRESET/COUNT registers and a maskable interrupt request.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic ctrl_wr, preset_wr, en_eff, auto_reload;

  assign ctrl_wr     = we && (addr == 2'd0);
  assign preset_wr   = we && (addr == 2'd1);
  // Enable as it will be after this edge, so a CTRL write steers the FSM on the write edge itself.
  assign en_eff      = ctrl_wr ? din[0] : ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (preset_wr) preset_d = din;
    // Auto-reload flag only lives for the cycle after INT.
    if (auto_reload) flag_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (en_eff) state_d = StLoad;
      end
      StLoad: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else begin
          count_d = preset_q;
          state_d = StCnt;
        end
      end
      StCnt: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else if (count_q == 32'd0) begin
          state_d = StInt;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      StInt: begin
        flag_d = 1'b1;
        if (auto_reload) begin
          state_d = en_eff ? StLoad : StIdle;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU write to CTRL overrides anything the FSM did this edge.
    if (ctrl_wr) begin
      ctrl_d = din[3:0];
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: one-shot, auto-reload, mask, zero preset,
// write/INT collision and asynchronous reset mid-count.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int tests = 0;
  int fails = 0;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Combinational read; costs 1 time unit.
  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Single-cycle write; returns 1 time unit after the write edge.
  task automatic write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    din  = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;

    // Reset state
    #2;
    check_reg("rst_ctrl", 2'd0, 32'd0);
    check_reg("rst_preset", 2'd1, 32'd0);
    check_reg("rst_count", 2'd2, 32'd0);
    check_irq("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // One-shot, PRESET=5: irq 8 cycles after the CTRL write edge
    write(2'd1, 32'd5);
    check_reg("os_preset", 2'd1, 32'd5);
    write(2'd0, 32'h9);
    step(3);
    check_reg("os_count_mid", 2'd2, 32'd3);
    step(4);
    check_irq("os_irq_e7", 1'b0);
    step(1);
    check_irq("os_irq_e8", 1'b1);
    check_reg("os_ctrl", 2'd0, 32'h8);
    check_reg("os_count", 2'd2, 32'd0);
    step(3);
    check_irq("os_irq_hold", 1'b1);
    check_reg("os_reserved", 2'd3, 32'd0);
    write(2'd2, 32'h1234);
    check_reg("os_count_ro", 2'd2, 32'd0);
    write(2'd0, 32'h8);
    check_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET=3: 1-cycle irq pulse every 6 cycles
    write(2'd1, 32'd3);
    write(2'd0, 32'hB);
    step(1);
    check_reg("ar_count_e1", 2'd2, 32'd3);
    step(4);
    check_irq("ar_irq_e5", 1'b0);
    step(1);
    check_irq("ar_irq_e6", 1'b1);
    step(1);
    check_irq("ar_irq_e7", 1'b0);
    check_reg("ar_reload", 2'd2, 32'd3);
    step(1);
    check_reg("ar_count_e8", 2'd2, 32'd2);
    step(2);
    check_reg("ar_count_e10", 2'd2, 32'd0);
    step(1);
    check_irq("ar_irq_e11", 1'b0);
    step(1);
    check_irq("ar_irq_e12", 1'b1);
    check_reg("ar_ctrl_en", 2'd0, 32'hB);
    step(1);
    check_irq("ar_irq_e13", 1'b0);
    // Rewriting CTRL with En=1 mid-count must not reload
    write(2'd0, 32'hB);
    check_reg("ar_no_reload", 2'd2, 32'd2);
    write(2'd0, 32'h0);
    step(3);
    check_reg("ar_stop_held", 2'd2, 32'd2);

    // Masked one-shot, PRESET=2: flag sets internally but irq stays 0
    write(2'd1, 32'd2);
    write(2'd0, 32'h1);
    for (int i = 0; i < 7; i++) begin
      check_irq("mask_irq", 1'b0);
      step(1);
    end
    check_reg("mask_count", 2'd2, 32'd0);
    check_reg("mask_ctrl", 2'd0, 32'd0);

    // PRESET=0: irq 3 cycles after the write, no wrap
    write(2'd1, 32'd0);
    write(2'd0, 32'h9);
    for (int i = 0; i < 2; i++) begin
      check_reg("zero_count", 2'd2, 32'd0);
      step(1);
    end
    check_irq("zero_irq_e2", 1'b0);
    step(1);
    check_irq("zero_irq_e3", 1'b1);
    check_reg("zero_count_end", 2'd2, 32'd0);
    check_reg("zero_ctrl", 2'd0, 32'h8);
    write(2'd0, 32'h0);

    // Collision: CTRL write on the edge leaving INT
    write(2'd1, 32'd1);
    write(2'd0, 32'h9);
    step(3);
    check_irq("col_irq_pre", 1'b0);
    write(2'd0, 32'h0);
    check_irq("col_irq_e4", 1'b0);
    check_reg("col_ctrl", 2'd0, 32'd0);
    step(3);
    check_irq("col_irq_late", 1'b0);

    // Asynchronous reset at COUNT=50
    write(2'd1, 32'd100);
    write(2'd0, 32'h9);
    step(51);
    check_reg("rm_count50", 2'd2, 32'd50);
    reset = 1'b0;
    #1;
    check_irq("rm_irq", 1'b0);
    check_reg("rm_ctrl", 2'd0, 32'd0);
    check_reg("rm_preset", 2'd1, 32'd0);
    check_reg("rm_count", 2'd2, 32'd0);
    step(2);
    @(negedge clk);
    reset = 1'b1;
    step(5);
    check_reg("rm_after_count", 2'd2, 32'd0);
    check_reg("rm_after_ctrl", 2'd0, 32'd0);
    check_irq("rm_after_irq", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameters: none; register map and widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 addr  input  2  word select from the CPU bridge address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write strobe; bridge asserts it only when the store address decodes to this device and the store has no exception.
REQ-006 din  input  32  write data from the CPU store path.
REQ-007 dout  output  32  read data to the CPU load path (Pr_RD).
REQ-008 irq  output  1  interrupt request; drives one HW[5:0] line of the CPU.

Function
REQ-009 CTRL holds 4 bits: [0] En (count enable), [2:1] Mode, [3] IM (interrupt mask, 1=enabled); dout bits [31:4] read 0.
REQ-010 Mode 00 = one-shot; Mode 01 = auto-reload; Modes 10/11 behave as 00.
REQ-011 Write addr 0: CTRL <= din[3:0], and the irq flag clears in the same edge.
REQ-012 Write addr 1: PRESET <= din; a write during counting affects only the next load.
REQ-013 Writes to addr 2 and 3 are ignored; COUNT is read-only.
REQ-014 dout is combinational from addr: 0 -> {28'b0,CTRL}, 1 -> PRESET, 2 -> COUNT, 3 -> 32'h0; zero read latency.
REQ-015 FSM states: IDLE, LOAD, CNT, INT.
REQ-016 IDLE: stay while En=0; En=1 -> LOAD.
REQ-017 LOAD: COUNT <= PRESET; -> CNT.
REQ-018 CNT: En=0 -> IDLE with COUNT held; COUNT==0 -> INT; otherwise COUNT <= COUNT-1.
REQ-019 INT, Mode 00: irq flag <= 1; CTRL.En <= 0; -> IDLE.
REQ-020 INT, Mode 01: irq flag <= 1 for exactly this edge's following cycle only; -> LOAD.
REQ-021 Mode 00 irq flag stays 1 until any CTRL write; Mode 01 flag self-clears one cycle after setting.
REQ-022 irq = irq flag AND CTRL.IM; combinational, no extra latency.
REQ-023 Latency from En write with PRESET=N to first irq assertion: exactly N+3 cycles (LOAD, N decrements, compare at 0, INT).
REQ-024 PRESET=0: reach INT directly after LOAD with no decrement and no wrap to 32'hFFFFFFFF.
REQ-025 COUNT never decrements below 0; no wrap-around.
REQ-026 A CPU CTRL write in the same cycle as INT (Mode 00) wins: CTRL takes din[3:0] and the flag is cleared, not set.
REQ-027 A CTRL write with En=0 in any state returns the FSM to IDLE on the next edge.
REQ-028 Writing CTRL with En=1 while in CNT does not reload; counting continues.

Reset
REQ-029 While reset=0: CTRL=0, PRESET=0, COUNT=0, irq flag=0, state=IDLE, irq=0, dout reflects zeroed registers.
REQ-030 Reset asserted mid-count aborts immediately (asynchronously); after release the device stays IDLE until CTRL.En is written.

Verification
REQ-031 One-shot: PRESET=5, then CTRL=4'b1001 -> irq rises 8 cycles after the CTRL write edge, CTRL reads 4'b1000, irq holds until a CTRL write, then drops the same cycle.
REQ-032 Auto-reload: PRESET=3, CTRL=4'b1011 -> irq is a 1-cycle pulse every 6 cycles, COUNT sequence 3,2,1,0 repeats, En stays 1.
REQ-033 Mask: PRESET=2, CTRL=4'b0001 -> irq stays 0 throughout; COUNT reaches 0 and En clears.
REQ-034 Boundary: PRESET=0, CTRL=4'b1001 -> irq asserts 3 cycles after the write; COUNT never reads 32'hFFFFFFFF.
REQ-035 Collision: a CTRL write 4'b0000 on the INT edge -> irq never asserts and CTRL reads 0.
REQ-036 Reset mid-count: PRESET=100, start, assert reset at COUNT=50 -> all reads return 0 and irq=0 immediately; after release, COUNT stays 0 with no further activity.
